// File: rtl/z80_idx_bitop_seq.sv
`default_nettype none
// ============================================================================
// Module  : z80_idx_bitop_seq
// Brief   : Sequencer for SET/RES b,(IX+d)/(IY+d): four-byte fetch plus the
//           read-modify-write of the target byte, with M/T-cycle accounting.
// Revision: 1.0 - initial release
// ============================================================================
module z80_idx_bitop_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] ip_in,
    input  logic [15:0] ix_in,
    input  logic [15:0] iy_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] ip_out,
    output logic        cyc_req,
    output logic [1:0]  cyc_type,
    output logic [1:0]  cyc_extra_t,
    output logic [15:0] cyc_addr,
    output logic [7:0]  cyc_wdata,
    input  logic        cyc_ack,
    input  logic [7:0]  cyc_rdata,
    output logic [2:0]  mcycles,
    output logic [4:0]  tcycles
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PFX  = 3'd1;
    localparam logic [2:0] S_CB   = 3'd2;
    localparam logic [2:0] S_DISP = 3'd3;
    localparam logic [2:0] S_OP   = 3'd4;
    localparam logic [2:0] S_RD   = 3'd5;
    localparam logic [2:0] S_WR   = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    localparam logic [1:0] CYC_NONE = 2'd0;
    localparam logic [1:0] CYC_M1   = 2'd1;
    localparam logic [1:0] CYC_RD   = 2'd2;
    localparam logic [1:0] CYC_WR   = 2'd3;

    logic [2:0]  state;
    logic [2:0]  state_nxt;

    logic [15:0] ip;
    logic [15:0] ix;
    logic [15:0] iy;
    logic [15:0] ea;
    logic        use_iy;
    logic        is_set;
    logic [2:0]  bit_sel;

    logic [15:0] ip_nxt;
    logic [15:0] ix_nxt;
    logic [15:0] iy_nxt;
    logic [15:0] ea_nxt;
    logic        use_iy_nxt;
    logic        is_set_nxt;
    logic [2:0]  bit_sel_nxt;

    logic        busy_nxt;
    logic        done_nxt;
    logic        err_nxt;
    logic [15:0] ip_out_nxt;
    logic        cyc_req_nxt;
    logic [1:0]  cyc_type_nxt;
    logic [1:0]  cyc_extra_t_nxt;
    logic [15:0] cyc_addr_nxt;
    logic [7:0]  cyc_wdata_nxt;
    logic [2:0]  mcycles_nxt;
    logic [4:0]  tcycles_nxt;

    logic        fire;
    logic        pfx_ok;
    logic        cb_ok;
    logic        op_ok;
    logic [15:0] base;
    logic [7:0]  bit_mask;
    logic [7:0]  modified;
    logic [4:0]  t_inc;

    always_comb begin
        fire     = cyc_req & cyc_ack;
        pfx_ok   = (cyc_rdata == 8'hDD) || (cyc_rdata == 8'hFD);
        cb_ok    = (cyc_rdata == 8'hCB);
        op_ok    = cyc_rdata[7] && (cyc_rdata[2:0] == 3'b110);
        base     = use_iy ? iy : ix;
        bit_mask = 8'b0000_0001 << bit_sel;
        modified = is_set ? (cyc_rdata | bit_mask) : (cyc_rdata & ~bit_mask);
        // M1 cycles carry one more T-state than plain memory cycles
        t_inc    = 5'd3 + {3'b000, cyc_extra_t} + {4'b0000, (cyc_type == CYC_M1)};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_PFX;
            S_PFX:  if (fire)  state_nxt = pfx_ok ? S_CB : S_DONE;
            S_CB:   if (fire)  state_nxt = cb_ok ? S_DISP : S_DONE;
            S_DISP: if (fire)  state_nxt = S_OP;
            S_OP:   if (fire)  state_nxt = op_ok ? S_RD : S_DONE;
            S_RD:   if (fire)  state_nxt = S_WR;
            S_WR:   if (fire)  state_nxt = S_DONE;
            S_DONE:            state_nxt = S_IDLE;
            default:           state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ip_nxt          = ip;
        ix_nxt          = ix;
        iy_nxt          = iy;
        ea_nxt          = ea;
        use_iy_nxt      = use_iy;
        is_set_nxt      = is_set;
        bit_sel_nxt     = bit_sel;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        err_nxt         = err;
        ip_out_nxt      = ip_out;
        cyc_req_nxt     = cyc_req;
        cyc_type_nxt    = cyc_type;
        cyc_extra_t_nxt = cyc_extra_t;
        cyc_addr_nxt    = cyc_addr;
        cyc_wdata_nxt   = cyc_wdata;
        mcycles_nxt     = mcycles;
        tcycles_nxt     = tcycles;

        if ((state == S_IDLE) && start) begin
            ip_nxt        = ip_in;
            ix_nxt        = ix_in;
            iy_nxt        = iy_in;
            err_nxt       = 1'b0;
            cyc_wdata_nxt = 8'h00;
            mcycles_nxt   = 3'd0;
            tcycles_nxt   = 5'd0;
        end

        if (fire) begin
            mcycles_nxt = mcycles + 3'd1;
            tcycles_nxt = tcycles + t_inc;
            case (state)
                S_PFX:  use_iy_nxt    = cyc_rdata[5];
                S_DISP: ea_nxt        = base + {{8{cyc_rdata[7]}}, cyc_rdata};
                S_OP: begin
                    is_set_nxt  = cyc_rdata[6];
                    bit_sel_nxt = cyc_rdata[5:3];
                end
                S_RD:   cyc_wdata_nxt = modified;
                default: ;
            endcase
        end

        // Bus fields are loaded only on a state change, so they stay put while a request waits
        if (state_nxt != state) begin
            case (state_nxt)
                S_PFX: begin
                    busy_nxt        = 1'b1;
                    cyc_req_nxt     = 1'b1;
                    cyc_type_nxt    = CYC_M1;
                    cyc_extra_t_nxt = 2'd0;
                    cyc_addr_nxt    = ip_in;
                end
                S_CB: begin
                    cyc_type_nxt    = CYC_M1;
                    cyc_extra_t_nxt = 2'd0;
                    cyc_addr_nxt    = ip + 16'd1;
                end
                S_DISP: begin
                    cyc_type_nxt    = CYC_RD;
                    cyc_extra_t_nxt = 2'd0;
                    cyc_addr_nxt    = ip + 16'd2;
                end
                S_OP: begin
                    cyc_type_nxt    = CYC_RD;
                    cyc_extra_t_nxt = 2'd2;
                    cyc_addr_nxt    = ip + 16'd3;
                end
                S_RD: begin
                    cyc_type_nxt    = CYC_RD;
                    cyc_extra_t_nxt = 2'd1;
                    cyc_addr_nxt    = ea;
                end
                S_WR: begin
                    cyc_type_nxt    = CYC_WR;
                    cyc_extra_t_nxt = 2'd0;
                    cyc_addr_nxt    = ea;
                end
                S_DONE: begin
                    busy_nxt        = 1'b0;
                    done_nxt        = 1'b1;
                    cyc_req_nxt     = 1'b0;
                    cyc_type_nxt    = CYC_NONE;
                    cyc_extra_t_nxt = 2'd0;
                    err_nxt         = (state != S_WR);
                    ip_out_nxt      = (state != S_WR) ? ip : (ip + 16'd4);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ip          <= 16'h0000;
            ix          <= 16'h0000;
            iy          <= 16'h0000;
            ea          <= 16'h0000;
            use_iy      <= 1'b0;
            is_set      <= 1'b0;
            bit_sel     <= 3'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ip_out      <= 16'h0000;
            cyc_req     <= 1'b0;
            cyc_type    <= CYC_NONE;
            cyc_extra_t <= 2'd0;
            cyc_addr    <= 16'h0000;
            cyc_wdata   <= 8'h00;
            mcycles     <= 3'd0;
            tcycles     <= 5'd0;
        end else begin
            ip          <= ip_nxt;
            ix          <= ix_nxt;
            iy          <= iy_nxt;
            ea          <= ea_nxt;
            use_iy      <= use_iy_nxt;
            is_set      <= is_set_nxt;
            bit_sel     <= bit_sel_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
            ip_out      <= ip_out_nxt;
            cyc_req     <= cyc_req_nxt;
            cyc_type    <= cyc_type_nxt;
            cyc_extra_t <= cyc_extra_t_nxt;
            cyc_addr    <= cyc_addr_nxt;
            cyc_wdata   <= cyc_wdata_nxt;
            mcycles     <= mcycles_nxt;
            tcycles     <= tcycles_nxt;
        end
    end

endmodule
`default_nettype wire
